// File: rtl/mant_mul_arbiter.sv
// Round-robin arbiter sharing one 4x4 mantissa multiplier among NREQ lanes.
// Optional macro MUL_PIPE_EN inserts a stage-1 register ahead of the response register.
module mant_mul_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [4*NREQ-1:0]   req_a,
    input  logic [4*NREQ-1:0]   req_b,
    output logic [3:0]          mul_a,
    output logic [3:0]          mul_b,
    input  logic [7:0]          mul_product,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ID_W-1:0]     rsp_id,
    output logic [7:0]          rsp_product
);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] rr_ptr_next;
    logic [ID_W-1:0] winner;
    logic            found;
    logic            can_accept;
    logic            transfer;

    // Two passes: lanes at or above rr_ptr first, then wrap to the lowest lane.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!found && req_valid[i] && (ID_W'(i) >= rr_ptr)) begin
                found  = 1'b1;
                winner = ID_W'(i);
            end
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!found && req_valid[i]) begin
                found  = 1'b1;
                winner = ID_W'(i);
            end
        end
    end

    assign transfer    = found & can_accept;
    assign rr_ptr_next = (winner == ID_W'(NREQ - 1)) ? '0 : winner + ID_W'(1);

    always_comb begin
        req_ready = '0;
        mul_a     = 4'h0;
        mul_b     = 4'h0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (transfer && (winner == ID_W'(i))) begin
                req_ready[i] = 1'b1;
                mul_a        = req_a[4*i +: 4];
                mul_b        = req_b[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (transfer) begin
            rr_ptr <= rr_ptr_next;
        end
    end

`ifdef MUL_PIPE_EN
    logic            s1_valid;
    logic [ID_W-1:0] s1_id;
    logic [7:0]      s1_product;
    logic            s1_adv;

    assign s1_adv     = !rsp_valid | rsp_ready;
    assign can_accept = !s1_valid | s1_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_id      <= '0;
            s1_product <= 8'h00;
        end else if (transfer) begin
            s1_valid   <= 1'b1;
            s1_id      <= winner;
            s1_product <= mul_product;
        end else if (s1_adv) begin
            s1_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_product <= 8'h00;
        end else if (s1_adv) begin
            rsp_valid <= s1_valid;
            if (s1_valid) begin
                rsp_id      <= s1_id;
                rsp_product <= s1_product;
            end
        end
    end
`else
    assign can_accept = !rsp_valid | rsp_ready;

    // Drain without a new transfer clears valid only; id/product keep their old values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_product <= 8'h00;
        end else if (transfer) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= winner;
            rsp_product <= mul_product;
        end else if (rsp_ready) begin
            rsp_valid   <= 1'b0;
        end
    end
`endif

endmodule
